// File: rtl/svm_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
// Shared definitions for the SVM dot-product pipeline:
//   - default fixed-point split of features/coefficients (Q4.28)
//   - control state encoding and per-beat pipeline tag
//   - accumulator width computation
//   - saturation of a wide signed value to an n-bit signed range
// -----------------------------------------------------------------------------
package svm_pkg;

    localparam int FEA_I_DEF = 4;
    localparam int FEA_F_DEF = 28;

    // Width of the generic saturation helper. It must cover the widest
    // accumulator the block is ever configured with (plus one guard bit).
    localparam int SAT_W = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,  // counter at 0, no partial window
        ST_ACC  = 1'b1   // at least one beat of the window accepted
    } ctrl_state_e;

    // Control tag that travels alongside each beat through the pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } beat_tag_t;

    // Full-precision products summed over every lane of every beat.
    function automatic int acc_w(input int fea_n, input int lanes, input int beats);
        return 2 * fea_n + $clog2(lanes * beats);
    endfunction

    // Clamp v into [-2^(n-1), 2^(n-1)-1]; caller keeps the low n bits.
    function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                        input int n);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) << (n - 1)) - SAT_W'(1);
        min_v = ~max_v;
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/svm_dot_pipe_if.sv
// -----------------------------------------------------------------------------
// svm_dot_pipe_if
// Beat/result bundle of the SVM dot-product pipeline.
//   i_fea/i_coef : LANES packed signed lanes, lane k at [(k+1)*FEA_N-1 : k*FEA_N]
//   i_bias       : signed bias, used on the last beat of a window
//   i_valid      : beat present (no backpressure)
//   i_clear      : synchronous abort of the current window
//   o_data       : saturated window score
//   o_class      : 1 when o_data >= 0
//   o_valid      : one-cycle result strobe
// master = beat source / result sink, slave = the pipeline.
// -----------------------------------------------------------------------------
interface svm_dot_pipe_if #(
    parameter int FEA_N = 32,
    parameter int LANES = 36
);
    logic [LANES*FEA_N-1:0] i_fea;
    logic [LANES*FEA_N-1:0] i_coef;
    logic [FEA_N-1:0]       i_bias;
    logic                   i_valid;
    logic                   i_clear;
    logic [FEA_N-1:0]       o_data;
    logic                   o_class;
    logic                   o_valid;

    modport master (
        output i_fea, i_coef, i_bias, i_valid, i_clear,
        input  o_data, o_class, o_valid
    );

    modport slave (
        input  i_fea, i_coef, i_bias, i_valid, i_clear,
        output o_data, o_class, o_valid
    );
endinterface

// File: rtl/svm_adder_tree.sv
// -----------------------------------------------------------------------------
// svm_adder_tree
// Combinational signed reduction of LANES packed IN_W-bit values into one
// OUT_W-bit sum. Built as a recursive binary split so depth is log2(LANES).
//   in_flat : LANES*IN_W packed signed operands, lane k at [k*IN_W +: IN_W]
//   sum     : signed total, OUT_W wide (must hold IN_W + clog2(LANES) bits)
// -----------------------------------------------------------------------------
module svm_adder_tree #(
    parameter int LANES = 4,
    parameter int IN_W  = 64,
    parameter int OUT_W = IN_W + $clog2(LANES)
) (
    input  logic [LANES*IN_W-1:0] in_flat,
    output logic signed [OUT_W-1:0] sum
);

    if (LANES == 1) begin : g_leaf
        assign sum = OUT_W'($signed(in_flat));
    end else begin : g_split
        localparam int LO = LANES / 2;
        localparam int HI = LANES - LO;

        logic signed [OUT_W-1:0] lo_sum;
        logic signed [OUT_W-1:0] hi_sum;

        svm_adder_tree #(.LANES(LO), .IN_W(IN_W), .OUT_W(OUT_W)) u_lo (
            .in_flat (in_flat[LO*IN_W-1:0]),
            .sum     (lo_sum)
        );

        svm_adder_tree #(.LANES(HI), .IN_W(IN_W), .OUT_W(OUT_W)) u_hi (
            .in_flat (in_flat[LANES*IN_W-1:LO*IN_W]),
            .sum     (hi_sum)
        );

        assign sum = lo_sum + hi_sum;
    end

endmodule

// File: rtl/svm_dot_pipe.sv
// -----------------------------------------------------------------------------
// svm_dot_pipe
// Windowed SVM score: sum over BEATS beats of LANES fixed-point products,
// plus bias, rescaled to Q(FEA_I.FEA_F) and saturated.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : svm_dot_pipe_if.slave (beats in, score/class/strobe out)
// Pipeline: S0 input capture + beat tags, S1 lane products, S2 lane sum,
// S3 accumulator, S4 rescale/saturate output register. A last beat accepted
// at edge T raises o_valid after edge T+4.
// -----------------------------------------------------------------------------
module svm_dot_pipe
    import svm_pkg::*;
#(
    parameter int FEA_I = FEA_I_DEF,
    parameter int FEA_F = FEA_F_DEF,
    parameter int LANES = 36,
    parameter int BEATS = 105
) (
    input  logic           clk,
    input  logic           rst,
    svm_dot_pipe_if.slave  bus
);

    localparam int FEA_N  = FEA_I + FEA_F;
    localparam int PROD_W = 2 * FEA_N;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int ACC_W  = acc_w(FEA_N, LANES, BEATS);
    localparam int EXT_W  = ACC_W + 1;  // guard bit for the bias addition
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    // ---------------- control ----------------
    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    beat_tag_t        s0_tag_q, s0_tag_d;
    beat_tag_t        s1_tag_q, s1_tag_d;
    beat_tag_t        s2_tag_q, s2_tag_d;
    beat_tag_t        s3_tag_q, s3_tag_d;
    logic             o_valid_q, o_valid_d;
    logic             o_class_q, o_class_d;
    logic [FEA_N-1:0] o_data_q, o_data_d;

    logic clear;
    logic accept;
    logic in_first;
    logic in_last;

    // ---------------- datapath ----------------
    logic [LANES*FEA_N-1:0]   s0_fea_q;
    logic [LANES*FEA_N-1:0]   s0_coef_q;
    logic signed [FEA_N-1:0]  s0_bias_q, s1_bias_q, s2_bias_q, s3_bias_q;
    logic [LANES*PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic signed [SUM_W-1:0]  s2_sum_q, s2_sum_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [EXT_W-1:0]  biased;
    logic signed [EXT_W-1:0]  scaled;

    assign clear    = bus.i_clear;
    assign accept   = bus.i_valid && !bus.i_clear;  // clear wins over a beat
    assign in_first = (state_q == ST_IDLE);          // counter is 0 exactly in IDLE
    assign in_last  = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        // NOTE: every _d takes a default before any branch, so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;

        if (clear) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
        end else if (accept) begin
            if (in_last) begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end else begin
                state_d    = ST_ACC;
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end

        s0_tag_d.vld   = accept;
        s0_tag_d.first = in_first;
        s0_tag_d.last  = in_last;

        // A clear kills every beat still in S0..S3 on its way to the next stage.
        s1_tag_d     = s0_tag_q;
        s1_tag_d.vld = s0_tag_q.vld && !clear;
        s2_tag_d     = s1_tag_q;
        s2_tag_d.vld = s1_tag_q.vld && !clear;
        s3_tag_d     = s2_tag_q;
        s3_tag_d.vld = s2_tag_q.vld && !clear;

        o_valid_d = s3_tag_q.vld && s3_tag_q.last && !clear;
    end

    // S1: full-width signed products, one per lane.
    always_comb begin
        s1_prod_d = '0;
        for (int k = 0; k < LANES; k++) begin
            logic signed [FEA_N-1:0] fa;
            logic signed [FEA_N-1:0] fb;
            fa = s0_fea_q[k*FEA_N +: FEA_N];
            fb = s0_coef_q[k*FEA_N +: FEA_N];
            s1_prod_d[k*PROD_W +: PROD_W] = PROD_W'(fa) * PROD_W'(fb);
        end
    end

    // S2: lane reduction.
    svm_adder_tree #(.LANES(LANES), .IN_W(PROD_W), .OUT_W(SUM_W)) u_tree (
        .in_flat (s1_prod_q),
        .sum     (s2_sum_d)
    );

    // S3: a first-tagged beat loads, so consecutive windows need no gap.
    always_comb begin
        acc_d = acc_q;
        if (s2_tag_q.vld) begin
            if (s2_tag_q.first) begin
                acc_d = ACC_W'(s2_sum_q);
            end else begin
                acc_d = acc_q + ACC_W'(s2_sum_q);
            end
        end
    end

    // S4: align bias to the product scale (2*FEA_F fractional bits), add,
    // drop FEA_F fractional bits with floor rounding, then saturate.
    always_comb begin
        biased    = EXT_W'(acc_q) + (EXT_W'(s3_bias_q) <<< FEA_F);
        scaled    = biased >>> FEA_F;
        o_data_d  = o_data_q;
        o_class_d = o_class_q;
        if (o_valid_d) begin
            o_data_d  = FEA_N'(sat_to(SAT_W'(scaled), FEA_N));
            o_class_d = ~o_data_d[FEA_N-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            s0_tag_q   <= '0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            s3_tag_q   <= '0;
            o_valid_q  <= 1'b0;
            o_class_q  <= 1'b0;
            o_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            s0_tag_q   <= s0_tag_d;
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
            s3_tag_q   <= s3_tag_d;
            o_valid_q  <= o_valid_d;
            o_class_q  <= o_class_d;
            o_data_q   <= o_data_d;
        end
    end

    // NOTE: datapath registers carry no reset; the tags alone decide whether
    // their contents are ever used.
    always_ff @(posedge clk) begin
        s0_fea_q  <= bus.i_fea;
        s0_coef_q <= bus.i_coef;
        s0_bias_q <= bus.i_bias;
        s1_prod_q <= s1_prod_d;
        s1_bias_q <= s0_bias_q;
        s2_sum_q  <= s2_sum_d;
        s2_bias_q <= s1_bias_q;
        acc_q     <= acc_d;
        s3_bias_q <= s2_bias_q;
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_class = o_class_q;
    assign bus.o_valid = o_valid_q;

endmodule

// File: doc/svm_dot_pipe.md
SVM_DOT_PIPE -- requirements
Module: svm_dot_pipe

Interface
REQ-001 Parameter FEA_I, default 4: integer bits of signed fixed-point feature/coefficient, sign bit included.
REQ-002 Parameter FEA_F, default 28: fractional bits; FEA_N = FEA_I+FEA_F.
REQ-003 Parameter LANES, default 36: products consumed per input beat.
REQ-004 Parameter BEATS, default 105: beats per detection window; minimum 1.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port i_fea, input, LANES*FEA_N: lane k at bits [(k+1)*FEA_N-1 : k*FEA_N], signed Q(FEA_I.FEA_F).
REQ-008 Port i_coef, input, LANES*FEA_N: SVM weights, same packing and format.
REQ-009 Port i_bias, input, FEA_N: signed bias; sampled on the last beat of a window.
REQ-010 Port i_valid, input, 1: beat present; always accepted, no backpressure.
REQ-011 Port i_clear, input, 1: synchronous abort of the current window.
REQ-012 Port o_data, output, FEA_N: saturated window score, signed Q(FEA_I.FEA_F), registered.
REQ-013 Port o_class, output, 1: 1 when o_data >= 0, else 0; registered.
REQ-014 Port o_valid, output, 1: one-cycle pulse qualifying o_data/o_class.

Function
REQ-015 Arithmetic SHALL be two's-complement signed throughout; each product full 2*FEA_N bits, no truncation.
REQ-016 Accumulator width SHALL be ACC_W = 2*FEA_N + clog2(LANES*BEATS); no internal overflow possible.
REQ-017 Pipeline: S1 registers LANES products; S2 registers lane sum; S3 accumulator; S4 output register.
REQ-018 Beat counter at input SHALL count accepted beats 0..BEATS-1, wrapping to 0; beat 0 tagged first, beat BEATS-1 tagged last (both when BEATS=1); tags and bias travel with data.
REQ-019 S3 SHALL load (not add) on a first-tagged beat, enabling back-to-back windows with zero gap.
REQ-020 On a last-tagged beat: result = (acc_final + (bias << FEA_F)) arithmetically shifted right by FEA_F (floor), saturated to [-2^(FEA_N-1), 2^(FEA_N-1)-1].
REQ-021 Last beat accepted at edge T SHALL produce o_valid high for exactly the cycle after edge T+4; o_data/o_class hold until next o_valid.
REQ-022 Control states: IDLE (counter 0, no partial window), ACC (counter >0); IDLE->ACC on valid beat when BEATS>1; ACC->IDLE on last beat or i_clear.
REQ-023 i_clear SHALL zero the counter and invalidate every in-flight S1-S3 beat; the in-cycle beat is discarded; clear wins over i_valid.
REQ-024 i_clear SHALL NOT cancel a result already in S4; o_data retains its last value.
REQ-025 Gaps (i_valid low) within a window SHALL be allowed without limit and not alter the result.

Reset
REQ-026 rst SHALL asynchronously force o_data=0, o_class=0, o_valid=0, counter=0, state IDLE, all pipeline valids/tags 0.
REQ-027 Reset mid-window SHALL discard the partial window; first beat after release is beat 0.

Structure
REQ-028 Package svm_pkg SHALL hold default FEA_I/FEA_F, ACC_W computation, and the saturation function.
REQ-029 Lane reduction SHALL be sub-module svm_adder_tree (parametrised LANES, width; combinational, registered by parent).

Verification (FEA_I=4, FEA_F=28, LANES=4, BEATS=2)
REQ-030 All fea 0x1000_0000, coef 0x0800_0000, bias 0, two beats at T-1,T -> o_data 0x4000_0000, o_class 1, o_valid after edge T+4 only.
REQ-031 fea 0x7000_0000, coef 0x7000_0000 -> 0x7FFF_FFFF; coef 0x9000_0000 -> 0x8000_0000, o_class 0.
REQ-032 Zero features, bias 0xF000_0000 -> o_data 0xF000_0000, o_class 0.
REQ-033 Beat 0, then i_clear with i_valid, then two clean beats of scenario 030 -> single o_valid, 0x4000_0000.
REQ-034 Four consecutive beats (windows A score 4.0, B score -2.0) -> two o_valid pulses two cycles apart, 0x4000_0000 then 0xE000_0000.
REQ-035 rst asserted after beat 0 -> outputs 0 immediately; post-release scenario 030 yields 0x4000_0000.
